stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes on every input and a single registered output stage. It selects one input channel per beat, either from a fixed select input or by round-robin arbitration. It sits between multiple producer streams and a single consumer. It replaces ad-hoc combinational select muxes wherever back-pressure, fairness or a registered boundary is needed.

## Interface
Parameters:
- NUM_CH, 4: number of input channels; legal range 2..16.
- WIDTH, 8: data width in bits; minimum 1.
- CH_W, $clog2(NUM_CH): derived width of channel indices; not overridable.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  selection mode: 0 = MODE_FIXED, 1 = MODE_RR.
- sel  input  CH_W  channel selected in MODE_FIXED; ignored in MODE_RR.
- in_valid  input  NUM_CH  per-channel valid.
- in_data  input  NUM_CH x WIDTH  per-channel data, unpacked array.
- in_ready  output  NUM_CH  per-channel ready; at most one bit high per cycle.
- out_valid  output  1  output beat valid.
- out_data  output  WIDTH  output beat data.
- out_ch  output  CH_W  index of the channel that produced the current output beat.
- out_ready  input  1  consumer ready.

## Operation
- Output stage FSM has two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Load condition: `load = grant_vld && (!out_valid || out_ready)`.
- Grant:
  - MODE_FIXED: `grant_vld = (sel < NUM_CH) && in_valid[sel]`. Granted channel is sel.
  - MODE_RR: search in_valid starting at `(last_ch+1) mod NUM_CH` and wrapping. The first set bit is granted. `grant_vld` is high if any in_valid is high.
- `in_ready[g] = load` for the granted channel g. All other in_ready bits are 0. in_ready is combinational from in_valid, sel, mode, out_valid and out_ready, and never depends on in_data.
- On load:
  - out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - In MODE_RR only: last_ch <= g.
- When out_valid && out_ready && !load: out_valid <= 0. out_data and out_ch hold their values.
- When out_valid && !out_ready: out_data and out_ch are held stable. No input is accepted.
- last_ch is updated only by MODE_RR grants. It is retained across mode switches.
- A mode or sel change takes effect on the same-cycle grant. A beat already in the output register is unaffected.
- sel >= NUM_CH (non-power-of-two NUM_CH) means no grant. This is not an error.
- Reset values:
  - out_valid=0, out_data='0, out_ch=0.
  - last_ch=NUM_CH-1, so after reset ch0 has first priority.
  - in_ready=0 whenever out_valid=0 and no input is valid.
- Reset asserted mid-operation drops any held beat immediately. No handshake completes in that cycle.

## Timing
- Latency: input handshake at edge N gives out_valid=1 with that beat after edge N.
- Throughput: one beat per cycle while out_ready is held high. There are no bubbles on simultaneous dequeue and load.
- Simultaneous out_ready and load in the FULL state: the old beat is consumed and the new beat replaces it on the same edge. The state stays FULL.
- Round-robin fairness: with all NUM_CH inputs continuously valid and out_ready high, each channel is granted exactly once per NUM_CH consecutive beats. Order is ch0, ch1, …, ch(NUM_CH-1), then repeats.
- A channel with in_valid low is skipped with no lost cycle.
- No combinational path from out_ready to out_data or out_valid.

## Structure
- Package stream_mux_pkg holds:
  - typedef enum logic {MODE_FIXED, MODE_RR} mux_mode_t.
  - Function next_rr(req, last) returning the grant index and a valid flag.
- One sub-module, rr_arbiter:
  - Combinational request-to-grant search, parametrised by NUM_CH.
  - Contains the last_ch register and its update on an accept strobe.
- stream_mux_rr instantiates rr_arbiter and contains:
  - Fixed-select path and mode mux.
  - Output register FSM.
  - in_ready decode.
- All combinational logic is coded with always_comb, with every output assigned on every path. No latches.

## Test plan
- Reset: assert rst_n=0 mid-transfer while out_valid=1 -> out_valid=0, out_ch=0, out_data=0 immediately. After release with all inputs valid in MODE_RR, the first out_ch is 0.
- MODE_FIXED, NUM_CH=4, sel=2, in_valid=4'b1111, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100, out_data=8'hA5 and out_ch=2 one cycle later. Continuous beats follow.
- MODE_RR, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with no gaps.
- MODE_RR, in_valid=4'b1010 -> out_ch alternates 1,3 with one beat per cycle.
- Back-pressure: out_ready=0 for 5 cycles with FULL output -> in_ready=0, out_data and out_ch stable. Next beat loads on the cycle out_ready returns to 1.
- Mode switch: after RR grant of ch1, switch to MODE_FIXED sel=3 for 2 beats, then back to MODE_RR with all inputs valid -> out_ch 3,3, then 2 (pointer retained at 1).

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and the round-robin search helper for the stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_t;

    localparam int MAX_CH   = 16;
    localparam int MAX_CH_W = 4;

    typedef struct packed {
        logic                vld;
        logic [MAX_CH_W-1:0] idx;
    } rr_grant_t;

    // First set request at or after (last+1) mod num_ch, wrapping once around.
    function automatic rr_grant_t next_rr(input logic [MAX_CH-1:0]   req,
                                          input logic [MAX_CH_W-1:0] last,
                                          input int                  num_ch);
        rr_grant_t g;
        int        c;
        g.vld = 1'b0;
        g.idx = '0;
        for (int k = 1; k <= MAX_CH; k++) begin
            c = (int'(last) + k) % num_ch;
            if (k <= num_ch && !g.vld && req[c]) begin
                g.vld = 1'b1;
                g.idx = MAX_CH_W'(c);
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin request search plus the last-granted pointer it rotates from.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              accept,
    output logic              gnt_vld,
    output logic [CH_W-1:0]   gnt_idx
);

    logic [CH_W-1:0]     last_ch;
    logic [MAX_CH-1:0]   req_ext;
    logic [MAX_CH_W-1:0] last_ext;
    rr_grant_t           g;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_CH-1:0]  = req;
        last_ext             = '0;
        last_ext[CH_W-1:0]   = last_ch;
        g                    = next_rr(req_ext, last_ext, NUM_CH);
        gnt_vld              = g.vld;
        gnt_idx              = CH_W'(g.idx);
    end

    // Pointer starts at the top channel so ch0 wins first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ch <= CH_W'(NUM_CH - 1);
        end else if (accept) begin
            last_ch <= gnt_idx;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed or round-robin selection and a
// single registered output stage.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [CH_W-1:0]   sel,
    input  logic [NUM_CH-1:0] in_valid,
    input  logic [WIDTH-1:0]  in_data [NUM_CH],
    output logic [NUM_CH-1:0] in_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [CH_W-1:0]   out_ch,
    input  logic              out_ready
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]      state;
    logic            rr_vld;
    logic [CH_W-1:0] rr_idx;
    logic            fix_vld;
    logic            grant_vld;
    logic [CH_W-1:0] grant_ch;
    logic            is_rr;
    logic            load;
    logic            rr_accept;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (in_valid),
        .accept  (rr_accept),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    // Out-of-range sel (non-power-of-two NUM_CH) simply yields no grant.
    always_comb begin
        fix_vld = 1'b0;
        if (32'(sel) < 32'(NUM_CH)) begin
            fix_vld = in_valid[sel];
        end
    end

    always_comb begin
        is_rr     = (mux_mode_t'(mode) == MODE_RR);
        out_valid = (state == ST_FULL);
        if (is_rr) begin
            grant_vld = rr_vld;
            grant_ch  = rr_idx;
        end else begin
            grant_vld = fix_vld;
            grant_ch  = sel;
        end
        load      = grant_vld && (!out_valid || out_ready);
        rr_accept = load && is_rr;
        in_ready  = '0;
        if (load) begin
            in_ready[grant_ch] = 1'b1;
        end
    end

    // Output register: a load always wins, so a dequeue and a new beat share an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_ch   <= '0;
        end else if (load) begin
            state    <= ST_FULL;
            out_data <= in_data[grant_ch];
            out_ch   <= grant_ch;
        end else if (out_ready) begin
            state    <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: stimulus queues expected beats, a monitor
// pops and compares each beat the consumer accepts.
module tb_stream_mux_rr;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mode;
    logic [CH_W-1:0]   sel;
    logic [NUM_CH-1:0] in_valid;
    logic [WIDTH-1:0]  in_data [NUM_CH];
    logic [NUM_CH-1:0] in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_ready;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_b;
    int    tests = 0;
    int    fails = 0;

    int fx_data [3] = '{'hA5, 'h3C, 'h5A};
    int rr8_ch  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int alt_ch  [4] = '{1, 3, 1, 3};

    always #5 clk = ~clk;

    stream_mux_rr #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int ch, input int data);
        exp_q.push_back(beat_t'{ch: CH_W'(ch), data: WIDTH'(data)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A beat completes on the next rising edge when valid and ready are both high here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mon_unexpected: got ch %0d data 0x%0h, expected no beat",
                         out_ch, out_data);
            end else begin
                mon_b = exp_q.pop_front();
                check("mon_ch", 32'(out_ch), 32'(mon_b.ch));
                check("mon_data", 32'(out_data), 32'(mon_b.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) in_data[c] = WIDTH'('hC0 + c);
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_ch", 32'(out_ch), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        rst_n = 1'b1;

        // Fixed select of channel 2, continuous beats
        mode      = 1'b0;
        sel       = 2'd2;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data[2] = WIDTH'(fx_data[0]);
        #1;
        check("fix_in_ready", 32'(in_ready), 'b0100);
        for (int i = 0; i < 3; i++) begin
            in_data[2] = WIDTH'(fx_data[i]);
            push(2, fx_data[i]);
            tick();
            if (i == 0) begin
                check("fix_lat_valid", 32'(out_valid), 1);
                check("fix_lat_data", 32'(out_data), 'hA5);
                check("fix_lat_ch", 32'(out_ch), 2);
            end
        end
        in_data[2] = WIDTH'('hC2);

        // Round robin, all valid: pointer never moved in fixed mode, so ch0 first
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(rr8_ch[i], 'hC0 + rr8_ch[i]);
            tick();
        end

        // Round robin, only ch1 and ch3 valid
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            push(alt_ch[i], 'hC0 + alt_ch[i]);
            tick();
        end
        in_valid = '0;
        tick();
        check("drain_empty", 32'(out_valid), 0);

        // Back-pressure with a full output register
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        push(0, 'hC0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_ch", 32'(out_ch), 0);
            check("bp_out_data", 32'(out_data), 'hC0);
            tick();
        end
        out_ready = 1'b1;
        push(1, 'hC1);
        tick();
        check("bp_resume_ch", 32'(out_ch), 1);

        // Mode switch: fixed sel=3 twice, then RR resumes after retained pointer (1)
        mode = 1'b0;
        sel  = 2'd3;
        #1;
        check("sw_in_ready", 32'(in_ready), 'b1000);
        push(3, 'hC3);
        tick();
        push(3, 'hC3);
        tick();
        mode = 1'b1;
        push(2, 'hC2);
        tick();
        push(3, 'hC3);
        tick();
        in_valid = '0;
        tick();

        // Reset in the middle of a held beat
        out_ready = 1'b0;
        in_valid  = 4'b0100;
        tick();
        check("pre_rst_valid", 32'(out_valid), 1);
        check("pre_rst_ch", 32'(out_ch), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_ch", 32'(out_ch), 0);
        check("mid_rst_data", 32'(out_data), 0);
        in_valid = '0;
        tick();
        rst_n     = 1'b1;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        push(0, 'hC0);
        tick();
        check("post_rst_ch", 32'(out_ch), 0);
        push(1, 'hC1);
        tick();
        in_valid = '0;
        tick();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
